// File: rtl/idma_txrx_write_arb_pkg.sv
// Shared types for the TXRX write arbiter.
// - IDMA_TXRX_ARB_TYPEDEF_BEAT: declares one write-beat struct (addr, data, strb, last).
//   Widths come from the including module's own parameters.
// - arb_state_e: arbiter FSM state.

`ifndef IDMA_TXRX_ARB_TYPEDEF_BEAT
`define IDMA_TXRX_ARB_TYPEDEF_BEAT(beat_t, addr_t, data_t, strb_t) \
    typedef struct packed { \
        addr_t addr; \
        data_t data; \
        strb_t strb; \
        logic  last; \
    } beat_t;
`endif

package idma_txrx_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/idma_txrx_write_arb_if.sv
// Bundle of the arbiter's handshake and bus signals.
// - slave:  arbiter view. Requester beats and downstream responses come in;
//           granted beats and routed responses go out.
// - master: environment view (requesters plus the downstream manager).
// - req_*:  per-requester beat channel, flat-packed NumReq-wide.
// - rsp_*:  per-requester response channel.
// - txrx_*: single downstream write port and its response channel.

interface idma_txrx_write_arb_if #(
    parameter int unsigned NumReq    = 2,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32
);
    logic [NumReq-1:0]               req_valid_i;
    logic [NumReq-1:0]               req_ready_o;
    logic [NumReq*AddrWidth-1:0]     req_addr_i;
    logic [NumReq*DataWidth-1:0]     req_data_i;
    logic [NumReq*DataWidth/8-1:0]   req_strb_i;
    logic [NumReq-1:0]               req_last_i;
    logic [NumReq-1:0]               rsp_valid_o;
    logic [NumReq-1:0]               rsp_ready_i;
    logic                            rsp_err_o;
    logic                            txrx_valid_o;
    logic                            txrx_ready_i;
    logic [AddrWidth-1:0]            txrx_addr_o;
    logic [DataWidth-1:0]            txrx_data_o;
    logic [DataWidth/8-1:0]          txrx_strb_o;
    logic                            txrx_last_o;
    logic                            txrx_rsp_valid_i;
    logic                            txrx_rsp_ready_o;
    logic                            txrx_rsp_err_i;

    modport slave (
        input  req_valid_i, req_addr_i, req_data_i, req_strb_i, req_last_i,
        input  rsp_ready_i, txrx_ready_i, txrx_rsp_valid_i, txrx_rsp_err_i,
        output req_ready_o, rsp_valid_o, rsp_err_o,
        output txrx_valid_o, txrx_addr_o, txrx_data_o, txrx_strb_o, txrx_last_o,
        output txrx_rsp_ready_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_data_i, req_strb_i, req_last_i,
        output rsp_ready_i, txrx_ready_i, txrx_rsp_valid_i, txrx_rsp_err_i,
        input  req_ready_o, rsp_valid_o, rsp_err_o,
        input  txrx_valid_o, txrx_addr_o, txrx_data_o, txrx_strb_o, txrx_last_o,
        input  txrx_rsp_ready_o
    );
endinterface

// File: rtl/idma_txrx_write_arb_id_fifo.sv
// Requester-ID FIFO. It records who issued each outstanding burst, in issue order.
// This is a registered-output FIFO with no fall-through. A push on a full FIFO is
// ignored, and a pop on an empty FIFO is ignored.
// Ports:
// - clk_i, rst_ni: clock and async active-low reset.
// - push_i, data_i: enqueue one ID.
// - pop_i: dequeue the head.
// - data_o: head entry, valid while !empty_o.
// - full_o, empty_o: occupancy flags.

module idma_txrx_write_arb_id_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    cnt_q;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (PtrW+1)'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/idma_txrx_write_arb.sv
// Round-robin write arbiter. It shares one TXRX write port among NumReq requesters.
// - The grant is taken at burst granularity and held until the last beat.
// - The requester ID of every issued burst is queued.
// - Each downstream response is routed back to the oldest queued ID.
// Ports:
// - clk_i, rst_ni: clock and async active-low reset.
// - bus: request, response and downstream channels (slave modport).
// - busy_o: high while a burst is locked or any burst awaits its response.
//
// state | meaning
// IDLE  | no burst in progress; round-robin pick; first beat needs a free ID slot
// BURST | locked to lock_q until its last beat; ID slot already reserved

module idma_txrx_write_arb
    import idma_txrx_arb_pkg::*;
#(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    idma_txrx_write_arb_if.slave  bus,
    output logic                  busy_o
);
    localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned StrbW = DataWidth / 8;

    typedef logic [IdxW-1:0]      idx_t;
    typedef logic [AddrWidth-1:0] addr_t;
    typedef logic [DataWidth-1:0] data_t;
    typedef logic [StrbW-1:0]     strb_t;
    `IDMA_TXRX_ARB_TYPEDEF_BEAT(beat_t, addr_t, data_t, strb_t)

    arb_state_e state_q, state_d;
    idx_t       lock_q, lock_d;
    idx_t       rr_q, rr_d;

    beat_t       req_beat [NumReq];
    beat_t       sel_beat;
    idx_t        rr_cand, gnt, head;
    logic        rr_found, granted, txrx_valid, beat_hs;
    logic        id_push, id_pop, fifo_full, fifo_empty;
    logic        txrx_rsp_ready;
    int unsigned scan_idx;
    logic [NumReq-1:0] req_ready, rsp_valid;

    for (genvar i = 0; i < NumReq; i++) begin : g_beat
        assign req_beat[i] = '{addr: bus.req_addr_i[i*AddrWidth +: AddrWidth],
                               data: bus.req_data_i[i*DataWidth +: DataWidth],
                               strb: bus.req_strb_i[i*StrbW +: StrbW],
                               last: bus.req_last_i[i]};
    end

    // First valid requester at or after rr_q, wrapping around.
    always_comb begin
        rr_cand  = rr_q;
        rr_found = 1'b0;
        scan_idx = 0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            scan_idx = (32'(rr_q) + k) % NumReq;
            if (!rr_found && bus.req_valid_i[idx_t'(scan_idx)]) begin
                rr_found = 1'b1;
                rr_cand  = idx_t'(scan_idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        rr_d    = rr_q;
        gnt     = rr_cand;
        granted = 1'b0;
        id_push = 1'b0;

        unique case (state_q)
            IDLE: begin
                gnt     = rr_cand;
                granted = rr_found & ~fifo_full;
            end
            BURST: begin
                gnt     = lock_q;
                granted = 1'b1;
            end
            default: ;
        endcase

        // Combinational outputs must read zero while reset is asserted,
        // even though requesters may still be driving valid.
        granted   = granted & rst_ni;
        sel_beat  = granted ? req_beat[gnt] : '0;
        txrx_valid = granted & bus.req_valid_i[gnt];
        req_ready = '0;
        req_ready[gnt] = granted & bus.txrx_ready_i;
        beat_hs   = txrx_valid & bus.txrx_ready_i;

        if (beat_hs) begin
            unique case (state_q)
                IDLE: begin
                    id_push = 1'b1;
                    rr_d    = (gnt == idx_t'(NumReq - 1)) ? '0 : gnt + 1'b1;
                    if (!sel_beat.last) begin
                        lock_d  = gnt;
                        state_d = BURST;
                    end
                end
                BURST: begin
                    if (sel_beat.last) begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            lock_q  <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            rr_q    <= rr_d;
        end
    end

    idma_txrx_write_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdxW)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (id_push),
        .data_i  (gnt),
        .pop_i   (id_pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        rsp_valid       = '0;
        rsp_valid[head] = bus.txrx_rsp_valid_i & ~fifo_empty;
    end

    assign txrx_rsp_ready = ~fifo_empty & bus.rsp_ready_i[head];
    assign id_pop         = bus.txrx_rsp_valid_i & txrx_rsp_ready;

    assign bus.req_ready_o      = req_ready;
    assign bus.txrx_valid_o     = txrx_valid;
    assign bus.txrx_addr_o      = sel_beat.addr;
    assign bus.txrx_data_o      = sel_beat.data;
    assign bus.txrx_strb_o      = sel_beat.strb;
    assign bus.txrx_last_o      = sel_beat.last;
    assign bus.rsp_valid_o      = rsp_valid;
    assign bus.rsp_err_o        = rst_ni & bus.txrx_rsp_err_i;
    assign bus.txrx_rsp_ready_o = txrx_rsp_ready;

    assign busy_o = (state_q == BURST) | ~fifo_empty;

endmodule

// File: tb/tb_idma_txrx_write_arb.sv
// Randomized scoreboard bench for idma_txrx_write_arb.
// - Stimulus: drivers push each beat they present into a per-requester queue.
// - Monitor (negedge): predicts the grant from round-robin/burst-lock rules and the
//   outstanding count, pops the expected beats, and checks the response routing
//   against the issue-order ID queue.

module tb_idma_txrx_write_arb;
    localparam int unsigned NumReq    = 2;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned StrbW     = DataWidth / 8;
    localparam int unsigned MaxOut    = 4;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [DataWidth-1:0] data;
        logic [StrbW-1:0]     strb;
        logic                 last;
    } beat_s;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic busy;

    idma_txrx_write_arb_if #(.NumReq(NumReq), .DataWidth(DataWidth), .AddrWidth(AddrWidth)) bus ();

    idma_txrx_write_arb #(
        .NumReq(NumReq), .DataWidth(DataWidth), .AddrWidth(AddrWidth), .MaxOutstanding(MaxOut)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_stall = 0;

    // scoreboard / reference model state
    beat_s exp_q [NumReq][$];
    int    m_ids[$];
    bit    owed_err[$];
    bit    m_locked = 0;
    int    m_lock = 0;
    int    m_rr = 0;
    int    m_beat_cnt = 0;

    // stimulus control
    bit gen_en = 0, rsp_en = 0, force_start = 0, tx_ready_all = 0;
    int min_len = 1, max_len = 4;
    int rem [NumReq];
    bit beat_done [NumReq];
    bit rsp_done = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: actual=timeout/unexpected required=event t=%0t", name, $time);
    endtask

    function automatic logic [NumReq-1:0] onehot(input int i);
        return NumReq'(1) << i;
    endfunction

    task automatic drive_beat(input int r, input logic last);
        beat_s b;
        b.addr = $urandom;
        b.data = $urandom;
        b.strb = StrbW'($urandom);
        b.last = last;
        bus.req_addr_i[r*AddrWidth +: AddrWidth] = b.addr;
        bus.req_data_i[r*DataWidth +: DataWidth] = b.data;
        bus.req_strb_i[r*StrbW +: StrbW]         = b.strb;
        bus.req_last_i[r]                        = last;
        exp_q[r].push_back(b);
    endtask

    // requester drivers
    initial begin
        bus.req_valid_i = '0;
        bus.req_addr_i  = '0;
        bus.req_data_i  = '0;
        bus.req_strb_i  = '0;
        bus.req_last_i  = '0;
        for (int r = 0; r < NumReq; r++) begin
            rem[r] = 0;
            beat_done[r] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            if (!rst_ni) begin
                bus.req_valid_i = '0;
                bus.req_last_i  = '0;
                for (int r = 0; r < NumReq; r++) begin
                    rem[r] = 0;
                    beat_done[r] = 0;
                end
            end else begin
                for (int r = 0; r < NumReq; r++) begin
                    if (beat_done[r]) begin
                        beat_done[r] = 0;
                        rem[r]--;
                        if (rem[r] > 0) drive_beat(r, rem[r] == 1);
                        else bus.req_valid_i[r] = 1'b0;
                    end
                    if (!bus.req_valid_i[r] && gen_en && (force_start || $urandom_range(0, 3) == 0)) begin
                        rem[r] = $urandom_range(min_len, max_len);
                        bus.req_valid_i[r] = 1'b1;
                        drive_beat(r, rem[r] == 1);
                    end
                end
            end
        end
    end

    // downstream manager and response consumers
    initial begin
        bus.txrx_ready_i     = 1'b0;
        bus.txrx_rsp_valid_i = 1'b0;
        bus.txrx_rsp_err_i   = 1'b0;
        bus.rsp_ready_i      = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_ni) begin
                bus.txrx_rsp_valid_i = 1'b0;
                rsp_done = 0;
            end else begin
                if (rsp_done) begin
                    bus.txrx_rsp_valid_i = 1'b0;
                    rsp_done = 0;
                end
                if (!bus.txrx_rsp_valid_i && rsp_en && owed_err.size() > 0 && $urandom_range(0, 2) == 0) begin
                    bus.txrx_rsp_valid_i = 1'b1;
                    bus.txrx_rsp_err_i   = owed_err[0];
                end
            end
            for (int r = 0; r < NumReq; r++) bus.rsp_ready_i[r] = ($urandom_range(0, 3) != 0);
            bus.txrx_ready_i = tx_ready_all ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    end

    // monitor + reference model
    initial begin
        forever begin
            @(negedge clk);
            if (rst_ni) begin
                int    g;
                int    head;
                beat_s b;
                g = -1;
                if (m_locked) begin
                    if (bus.req_valid_i[m_lock]) g = m_lock;
                end else if (m_ids.size() < MaxOut) begin
                    for (int k = 0; k < NumReq; k++) begin
                        int r;
                        r = (m_rr + k) % NumReq;
                        if (g < 0 && bus.req_valid_i[r]) g = r;
                    end
                end else if (bus.req_valid_i != '0) begin
                    n_stall++;
                end

                chk("busy", busy, m_locked || m_ids.size() > 0);
                chk("txrx_valid", bus.txrx_valid_o, g >= 0);

                if (g < 0 && !m_locked) begin
                    chk("req_ready_idle", bus.req_ready_o, '0);
                    chk("txrx_addr_idle", bus.txrx_addr_o, '0);
                end

                if (g >= 0) begin
                    if (exp_q[g].size() == 0) begin
                        fail("beat_queue_empty");
                    end else begin
                        b = exp_q[g][0];
                        chk("txrx_addr", bus.txrx_addr_o, b.addr);
                        chk("txrx_data", bus.txrx_data_o, b.data);
                        chk("txrx_strb", bus.txrx_strb_o, b.strb);
                        chk("txrx_last", bus.txrx_last_o, b.last);
                        chk("req_ready", bus.req_ready_o, bus.txrx_ready_i ? onehot(g) : '0);
                        if (bus.txrx_ready_i) begin
                            void'(exp_q[g].pop_front());
                            beat_done[g] = 1;
                            if (!m_locked) begin
                                m_ids.push_back(g);
                                m_rr = (g + 1) % NumReq;
                                m_beat_cnt = 0;
                            end
                            m_beat_cnt++;
                            if (b.last) begin
                                m_locked = 0;
                                owed_err.push_back($urandom_range(0, 1) == 1);
                            end else begin
                                m_locked = 1;
                                m_lock = g;
                            end
                        end
                    end
                end

                if (bus.txrx_rsp_valid_i) begin
                    if (m_ids.size() == 0 || owed_err.size() == 0) begin
                        fail("rsp_without_outstanding");
                    end else begin
                        head = m_ids[0];
                        chk("rsp_valid", bus.rsp_valid_o, onehot(head));
                        chk("rsp_err", bus.rsp_err_o, owed_err[0]);
                        chk("txrx_rsp_ready", bus.txrx_rsp_ready_o, bus.rsp_ready_i[head]);
                        if (bus.rsp_ready_i[head]) begin
                            void'(m_ids.pop_front());
                            void'(owed_err.pop_front());
                            rsp_done = 1;
                        end
                    end
                end else begin
                    chk("rsp_valid_idle", bus.rsp_valid_o, '0);
                    if (m_ids.size() == 0) chk("txrx_rsp_ready_empty", bus.txrx_rsp_ready_o, 1'b0);
                end
            end
        end
    end

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (!(m_ids.size() == 0 && !m_locked && bus.req_valid_i == '0 && !bus.txrx_rsp_valid_i)
               && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= limit) fail("drain_timeout");
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_txrx_valid"}, bus.txrx_valid_o, 1'b0);
        chk({tag, "_req_ready"}, bus.req_ready_o, '0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid_o, '0);
        chk({tag, "_txrx_rsp_ready"}, bus.txrx_rsp_ready_o, 1'b0);
        chk({tag, "_txrx_addr"}, bus.txrx_addr_o, '0);
        chk({tag, "_txrx_data"}, bus.txrx_data_o, '0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic clear_model();
        for (int r = 0; r < NumReq; r++) exp_q[r].delete();
        m_ids.delete();
        owed_err.delete();
        m_locked = 0;
        m_lock = 0;
        m_rr = 0;
        m_beat_cnt = 0;
    endtask

    initial begin
        int lim;
        #12;
        check_outputs_zero("reset");
        #10;
        rst_ni = 1'b1;

        // rotation: both requesters start 3-beat bursts together, downstream always ready
        tx_ready_all = 1;
        rsp_en = 1;
        min_len = 3;
        max_len = 3;
        gen_en = 1;
        force_start = 1;
        @(posedge clk);
        #2;
        force_start = 0;
        gen_en = 0;
        wait_idle(200);
        tx_ready_all = 0;

        // random traffic
        min_len = 1;
        max_len = 4;
        gen_en = 1;
        repeat (500) @(posedge clk);

        // fill the ID FIFO with responses withheld
        min_len = 1;
        max_len = 2;
        rsp_en = 0;
        repeat (80) @(posedge clk);

        // alternate response availability so full/pop coincide
        repeat (16) begin
            rsp_en = ~rsp_en;
            repeat ($urandom_range(5, 40)) @(posedge clk);
        end
        rsp_en = 1;
        gen_en = 0;
        wait_idle(1000);
        chk("fifo_full_stall_seen", n_stall > 0, 1'b1);

        // reset during beat 2 of a 4-beat burst
        min_len = 4;
        max_len = 4;
        gen_en = 1;
        lim = 0;
        while (!(m_locked && m_beat_cnt == 1) && lim < 200) begin
            @(negedge clk);
            #1;
            lim++;
        end
        if (lim >= 200) fail("midburst_wait");
        rst_ni = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        gen_en = 0;
        clear_model();
        repeat (3) @(negedge clk);
        #2;
        check_outputs_zero("held_reset");
        rst_ni = 1'b1;

        // after reset both start together; model expects req0 first
        min_len = 1;
        max_len = 4;
        gen_en = 1;
        force_start = 1;
        @(posedge clk);
        #2;
        force_start = 0;
        repeat (300) @(posedge clk);
        gen_en = 0;
        wait_idle(1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
